ex_wb_stage: RTL and testbench

//  Execute->writeback pipeline stage placed directly downstream of the execute unit.

---
 rtl/ex_wb_stage_pkg.sv | 8 +
 rtl/ex_wb_stage_if.sv | 10 +
 rtl/ex_wb_stage_rslt_mux.sv | 24 ++
 rtl/ex_wb_stage.sv | 110 +++++++++++
 tb/tb_ex_wb_stage.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_wb_stage_pkg.sv
// ex_wb_pkg: stage FSM encoding and result-select codes shared by the EX->WB stage files
package ex_wb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, MD_WAIT = 2'd1, DRAIN = 2'd2} state_t;
  localparam logic [1:0] RSLT_ADD  = 2'b00;
  localparam logic [1:0] RSLT_SHFT = 2'b01;
  localparam logic [1:0] RSLT_ARLG = 2'b10;
  localparam logic [1:0] RSLT_MD   = 2'b11;
endpackage

// File: rtl/ex_wb_stage_if.sv
// ex_wb_if: writeback bus (master drives wb_valid/wb_rd/wb_we/wb_data, slave drives wb_ready)
interface ex_wb_if #(parameter int W = 32, parameter int RD_W = 5);
  logic wb_valid;
  logic wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic wb_we;
  logic [W-1:0] wb_data;
  modport master(output wb_valid, wb_rd, wb_we, wb_data, input wb_ready);
  modport slave(input wb_valid, wb_rd, wb_we, wb_data, output wb_ready);
endinterface

// File: rtl/ex_wb_stage_rslt_mux.sv
// ex_wb_rslt_mux: picks the stage result (jump link overrides rslt_sel; ports: selects, unit results in, result out)
module ex_wb_rslt_mux import ex_wb_pkg::*; #(parameter int W = 32) (
  input  logic [1:0]   rslt_sel,
  input  logic         is_jump,
  input  logic [W+1:0] adder_result,
  input  logic [W-1:0] shft_result,
  input  logic [W-1:0] arth_log_result,
  input  logic [W-1:0] md_result,
  input  logic [W-1:0] jmp_pc4,
  output logic [W-1:0] result
);
  logic unused_carry;
  assign unused_carry = ^adder_result[W+1:W];
  always_comb begin
    result = md_result;
    case (rslt_sel)
      RSLT_ADD:  result = adder_result[W-1:0];
      RSLT_SHFT: result = shft_result;
      RSLT_ARLG: result = arth_log_result;
      RSLT_MD:   result = md_result;
    endcase
    if (is_jump) result = jmp_pc4;
  end
endmodule

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: EX->WB stage with mul/div hold, watchdog and wb register (ports: ex side in, wb bus master, fwd bus, md status)
module ex_wb_stage import ex_wb_pkg::*; #(
  parameter int W = 32,
  parameter int RD_W = 5,
  parameter int MD_TMO = 64
) (
  input  logic            clk,
  input  logic            a_rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [1:0]      rslt_sel,
  input  logic            is_jump,
  input  logic            mul_act,
  input  logic            div_act,
  input  logic [W+1:0]    adder_result,
  input  logic [W-1:0]    shft_result,
  input  logic [W-1:0]    arth_log_result,
  input  logic [W-1:0]    mul_result,
  input  logic [W-1:0]    div_result,
  input  logic            mul_rdy,
  input  logic            div_rdy,
  input  logic [W-1:0]    jmp_pc4,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_useRd,
  input  logic            flush,
  ex_wb_if.master         wb,
  output logic            fwd_valid,
  output logic [RD_W-1:0] fwd_rd,
  output logic [W-1:0]    fwd_data,
  output logic            md_busy,
  output logic            md_timeout
);
  localparam int CW = $clog2(MD_TMO);
  state_t state, state_n;
  logic [CW-1:0] md_cnt;
  logic md_hit, md_div, md_we, md_rdy, md_have, tmo, slot_free, accept, ld_ex, ld_md;
  logic [RD_W-1:0] md_rd, wb_rd_q;
  logic [W-1:0] md_buf, md_live, ex_rslt, wb_data_q;
  logic wb_valid_q, wb_we_q;
  ex_wb_rslt_mux #(.W(W)) u_mux (
    .rslt_sel(rslt_sel),
    .is_jump(is_jump),
    .adder_result(adder_result),
    .shft_result(shft_result),
    .arth_log_result(arth_log_result),
    .md_result(div_act ? div_result : mul_result),
    .jmp_pc4(jmp_pc4),
    .result(ex_rslt)
  );
  assign slot_free = !wb_valid_q || wb.wb_ready;
  assign ex_ready = state == IDLE && slot_free && !flush;
  assign accept = ex_valid && ex_ready;
  assign md_busy = state == MD_WAIT || state == DRAIN;
  assign md_rdy = md_div ? div_rdy : mul_rdy;
  assign md_live = md_div ? div_result : mul_result;
  assign md_have = md_hit || md_rdy;
  assign tmo = md_busy && md_cnt == CW'(MD_TMO - 1);
  assign ld_ex = accept && !mul_act && !div_act;
  assign ld_md = state == MD_WAIT && md_have && slot_free && !flush && !tmo;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = accept && (mul_act || div_act) ? MD_WAIT : IDLE;
      MD_WAIT: state_n = tmo || ld_md || (flush && md_have) ? IDLE : flush ? DRAIN : MD_WAIT;
      DRAIN:   state_n = tmo || md_rdy ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (a_rst) begin
      state <= IDLE;
      md_cnt <= '0;
      md_hit <= 1'b0;
      md_buf <= '0;
      md_div <= 1'b0;
      md_rd <= '0;
      md_we <= 1'b0;
      md_timeout <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q <= '0;
      wb_we_q <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state <= state_n;
      md_cnt <= md_busy && state_n != IDLE ? md_cnt + 1'b1 : '0;
      md_hit <= state == MD_WAIT && state_n == MD_WAIT && md_have;
      if (state == MD_WAIT && !md_hit && md_rdy) md_buf <= md_live;
      if (tmo) md_timeout <= 1'b1;
      if (accept) begin
        md_div <= div_act;
        md_rd <= ex_rd;
        md_we <= ex_useRd && ex_rd != '0;
      end
      if (flush) wb_valid_q <= 1'b0;
      else if (ld_ex || ld_md) begin
        wb_valid_q <= 1'b1;
        wb_rd_q <= ld_md ? md_rd : ex_rd;
        wb_we_q <= ld_md ? md_we : ex_useRd && ex_rd != '0;
        wb_data_q <= ld_md ? (md_hit ? md_buf : md_live) : ex_rslt;
      end else if (wb.wb_ready) wb_valid_q <= 1'b0;
    end
  end
  assign wb.wb_valid = wb_valid_q;
  assign wb.wb_rd = wb_rd_q;
  assign wb.wb_we = wb_we_q;
  assign wb.wb_data = wb_data_q;
  assign fwd_valid = wb_valid_q && wb_we_q;
  assign fwd_rd = wb_rd_q;
  assign fwd_data = wb_data_q;
endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage: scoreboard bench for ex_wb_stage
module tb_ex_wb_stage;
  localparam int W = 32, RD_W = 5, MD_TMO = 64;
  typedef struct packed {logic [RD_W-1:0] rd; logic we; logic [W-1:0] data;} wb_t;
  logic clk = 1'b0, a_rst = 1'b1;
  logic ex_valid = 1'b0, ex_ready;
  logic [1:0] rslt_sel = 2'b00;
  logic is_jump = 1'b0, mul_act = 1'b0, div_act = 1'b0;
  logic [W+1:0] adder_result = '0;
  logic [W-1:0] shft_result = '0, arth_log_result = '0, mul_result = '0, div_result = '0, jmp_pc4 = '0;
  logic mul_rdy = 1'b0, div_rdy = 1'b0;
  logic [RD_W-1:0] ex_rd = '0;
  logic ex_useRd = 1'b0, flush = 1'b0;
  logic fwd_valid, md_busy, md_timeout;
  logic [RD_W-1:0] fwd_rd;
  logic [W-1:0] fwd_data;
  int errors = 0, checks = 0;
  wb_t exp_q[$];
  ex_wb_if #(.W(W), .RD_W(RD_W)) wb();
  ex_wb_stage #(.W(W), .RD_W(RD_W), .MD_TMO(MD_TMO)) dut (
    .clk(clk), .a_rst(a_rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .rslt_sel(rslt_sel), .is_jump(is_jump), .mul_act(mul_act), .div_act(div_act),
    .adder_result(adder_result), .shft_result(shft_result), .arth_log_result(arth_log_result),
    .mul_result(mul_result), .div_result(div_result), .mul_rdy(mul_rdy), .div_rdy(div_rdy),
    .jmp_pc4(jmp_pc4), .ex_rd(ex_rd), .ex_useRd(ex_useRd), .flush(flush), .wb(wb),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .md_busy(md_busy), .md_timeout(md_timeout)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    wb_t got, e;
    if (wb.wb_valid === 1'b1 && wb.wb_ready === 1'b1) begin
      got = {wb.wb_rd, wb.wb_we, wb.wb_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d we=%0b data=%h, expected no transfer", got.rd, got.we, got.data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL wb_transfer: got rd=%0d we=%0b data=%h, expected rd=%0d we=%0b data=%h",
                   got.rd, got.we, got.data, e.rd, e.we, e.data);
        end
      end
      checks++;
      if (fwd_valid !== wb.wb_we || fwd_rd !== wb.wb_rd || fwd_data !== wb.wb_data) begin
        errors++;
        $display("FAIL fwd_bus: got v=%0b rd=%0d data=%h, expected v=%0b rd=%0d data=%h",
                 fwd_valid, fwd_rd, fwd_data, wb.wb_we, wb.wb_rd, wb.wb_data);
      end
    end
  end
  task automatic set_op(input logic [1:0] sel, input logic jmp, input logic mul, input logic div,
                        input logic [RD_W-1:0] rd, input logic use_rd);
    ex_valid = 1'b1; rslt_sel = sel; is_jump = jmp; mul_act = mul; div_act = div; ex_rd = rd; ex_useRd = use_rd;
  endtask
  task automatic clr_op();
    ex_valid = 1'b0; is_jump = 1'b0; mul_act = 1'b0; div_act = 1'b0;
  endtask
  task automatic test_reset();
    a_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wb.wb_valid !== 1'b0 || fwd_valid !== 1'b0 || md_busy !== 1'b0 || md_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got wb_valid=%b fwd_valid=%b md_busy=%b md_timeout=%b, expected all 0",
               wb.wb_valid, fwd_valid, md_busy, md_timeout);
    end
    checks++;
    if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got ex_ready=%b, expected 1", ex_ready); end
    @(posedge clk); #1;
  endtask
  task automatic test_single();
    wb.wb_ready = 1'b1;
    adder_result = 34'h3_0000_0010;
    set_op(2'b00, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
    exp_q.push_back({5'd5, 1'b1, 32'h10});
    @(negedge clk);
    checks++;
    if (ex_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got ex_ready=%b, expected 1", ex_ready); end
    @(posedge clk); #1 clr_op();
    @(negedge clk);
    checks++;
    if (wb.wb_valid !== 1'b1 || wb.wb_rd !== 5'd5 || wb.wb_data !== 32'h10 || fwd_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_wb: got v=%b rd=%0d data=%h fwd=%b, expected v=1 rd=5 data=00000010 fwd=1",
               wb.wb_valid, wb.wb_rd, wb.wb_data, fwd_valid);
    end
    shft_result = 32'h0000_ABCD;
    set_op(2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    exp_q.push_back({5'd0, 1'b0, 32'hABCD});
    @(posedge clk); #1 clr_op();
    @(negedge clk);
    checks++;
    if (wb.wb_valid !== 1'b1 || wb.wb_we !== 1'b0 || fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd0_we: got v=%b we=%b fwd=%b, expected v=1 we=0 fwd=0", wb.wb_valid, wb.wb_we, fwd_valid);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_mul_backpressure();
    int bad = 0;
    wb.wb_ready = 1'b1;
    mul_result = 32'hDEAD_0000;
    set_op(2'b11, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1);
    exp_q.push_back({5'd3, 1'b1, 32'h1234_5678});
    @(negedge clk);
    checks++;
    if (ex_ready !== 1'b1) begin errors++; $display("FAIL mul_accept: got ex_ready=%b, expected 1", ex_ready); end
    @(posedge clk); #1 clr_op();
    for (int k = 1; k <= 45; k++) begin
      wb.wb_ready = !(k >= 30 && k <= 40);
      mul_rdy = (k == 35);
      div_rdy = (k == 20);
      mul_result = (k == 35) ? 32'h1234_5678 : (32'hDEAD_0000 | 32'(k));
      div_result = 32'hBAD0_0000 | 32'(k);
      @(negedge clk);
      if (k <= 40 && ex_ready !== 1'b0) bad++;
      if (k <= 35 && (wb.wb_valid !== 1'b0 || md_busy !== 1'b1)) bad++;
      if (k == 38) begin
        checks++;
        if (wb.wb_valid !== 1'b1 || wb.wb_data !== 32'h1234_5678) begin
          errors++;
          $display("FAIL mul_hold: got v=%b data=%h, expected v=1 data=12345678", wb.wb_valid, wb.wb_data);
        end
      end
      @(posedge clk); #1;
    end
    mul_rdy = 1'b0; div_rdy = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mul_stall: got %0d bad cycles, expected 0", bad); end
    @(negedge clk);
    checks++;
    if (ex_ready !== 1'b1 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_done: got ex_ready=%b md_busy=%b, expected 1 0", ex_ready, md_busy);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_div_flush();
    int bad = 0;
    wb.wb_ready = 1'b1;
    set_op(2'b11, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
    @(negedge clk);
    checks++;
    if (ex_ready !== 1'b1) begin errors++; $display("FAIL div_accept: got ex_ready=%b, expected 1", ex_ready); end
    @(posedge clk); #1 clr_op();
    for (int k = 1; k <= 40; k++) begin
      flush = (k == 3);
      div_rdy = (k == 33);
      mul_rdy = (k == 20);
      div_result = 32'hFEED_0000 | 32'(k);
      mul_result = 32'hCAFE_0000 | 32'(k);
      @(negedge clk);
      if (wb.wb_valid !== 1'b0) bad++;
      if (k <= 33 && (ex_ready !== 1'b0 || md_busy !== 1'b1)) bad++;
      if (k > 34 && (ex_ready !== 1'b1 || md_busy !== 1'b0)) bad++;
      if (k == 34) begin
        checks++;
        if (ex_ready !== 1'b1 || md_busy !== 1'b0) begin
          errors++;
          $display("FAIL drain_exit: got ex_ready=%b md_busy=%b, expected 1 0", ex_ready, md_busy);
        end
      end
      @(posedge clk); #1;
    end
    flush = 1'b0; div_rdy = 1'b0; mul_rdy = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL div_flush: got %0d bad cycles, expected 0", bad); end
  endtask
  task automatic test_timeout();
    int bad = 0;
    wb.wb_ready = 1'b1;
    set_op(2'b11, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1);
    @(posedge clk); #1 clr_op();
    for (int k = 1; k <= 70; k++) begin
      div_rdy = (k == 10);
      mul_rdy = (k == 68);
      @(negedge clk);
      if (wb.wb_valid !== 1'b0) bad++;
      if (k <= 64 && (md_timeout !== 1'b0 || md_busy !== 1'b1)) bad++;
      if (k > 65 && (md_timeout !== 1'b1 || md_busy !== 1'b0)) bad++;
      if (k == 65) begin
        checks++;
        if (md_timeout !== 1'b1 || md_busy !== 1'b0 || ex_ready !== 1'b1) begin
          errors++;
          $display("FAIL md_timeout: got tmo=%b busy=%b ex_ready=%b, expected 1 0 1", md_timeout, md_busy, ex_ready);
        end
      end
      @(posedge clk); #1;
    end
    div_rdy = 1'b0; mul_rdy = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL tmo_window: got %0d bad cycles, expected 0", bad); end
  endtask
  task automatic test_back_to_back();
    int bad = 0, vcount = 0;
    logic [1:0] sel_t[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic jmp_t[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] dat_t[4] = '{32'hA1, 32'hE5, 32'hC3, 32'hD4};
    wb.wb_ready = 1'b1;
    adder_result = 34'h2_0000_00A1; shft_result = 32'hB2; arth_log_result = 32'hC3;
    mul_result = 32'hD4; div_result = 32'h55; jmp_pc4 = 32'hE5;
    for (int i = 0; i < 4; i++) begin
      set_op(sel_t[i], jmp_t[i], 1'b0, 1'b0, RD_W'(i + 1), 1'b1);
      exp_q.push_back({RD_W'(i + 1), 1'b1, dat_t[i]});
      @(negedge clk);
      if (ex_ready !== 1'b1) bad++;
      if (i > 0 && wb.wb_valid === 1'b1) vcount++;
      @(posedge clk); #1;
    end
    clr_op();
    @(negedge clk);
    if (wb.wb_valid === 1'b1) vcount++;
    checks++;
    if (vcount != 4 || bad != 0) begin
      errors++;
      $display("FAIL b2b: got %0d valid cycles %0d stalls, expected 4 valid 0 stalls", vcount, bad);
    end
    @(posedge clk); #1;
    adder_result = 34'h61;
    set_op(2'b00, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1);
    exp_q.push_back({5'd6, 1'b1, 32'h61});
    @(posedge clk); #1;
    set_op(2'b10, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1);
    exp_q.push_back({5'd7, 1'b1, 32'hC3});
    @(posedge clk); #1;
    set_op(2'b01, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
    a_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (md_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got md_timeout=%b, expected 1", md_timeout); end
    @(posedge clk); #1 a_rst = 1'b0; clr_op();
    @(negedge clk);
    checks++;
    if (wb.wb_valid !== 1'b0 || md_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got wb_valid=%b md_timeout=%b, expected 0 0", wb.wb_valid, md_timeout);
    end
    @(posedge clk); #1;
    set_op(2'b11, 1'b0, 1'b1, 1'b0, 5'd10, 1'b1);
    @(posedge clk); #1 clr_op();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL rst_md_pre: got md_busy=%b, expected 1", md_busy); end
    @(posedge clk); #1 a_rst = 1'b1;
    @(posedge clk); #1 a_rst = 1'b0; mul_rdy = 1'b1; mul_result = 32'h99;
    @(posedge clk); #1 mul_rdy = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (wb.wb_valid !== 1'b0 || md_busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_md_ignore: got %0d bad cycles, expected 0", bad); end
  endtask
  initial begin
    wb.wb_ready = 1'b1;
    test_reset();
    test_single();
    test_mul_backpressure();
    test_div_flush();
    test_timeout();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending results, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
